mem_1r1w_bist: RTL and testbench

March-test BIST controller that drives the R0/W0 port set of a 1-read/1-write lowered memory wrapper. It acts as the client end of those ports: it writes patterns, reads them back one cycle later, and compares the results. It sits beside each lowered memory and runs when the memory test hub pulses start; the memory's R0_clk and W0_clk are tied to this block's clock. The algorithm is a reduced March C-: W(bg)↑, R(bg)W(~bg)↑, R(~bg)W(bg)↓, R(bg)↑.

---
 rtl/mem_1r1w_bist_pkg.sv | 33 +++
 rtl/mem_1r1w_bist_if.sv | 24 ++
 rtl/mem_1r1w_bist_checker.sv | 76 +++++++
 rtl/mem_1r1w_bist.sv | 226 ++++++++++++++++++++++
 tb/tb_mem_1r1w_bist.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_1r1w_bist_pkg.sv
// Shared types and helpers for the 1R1W March C- memory BIST.
package mem_bist_pkg;

    // Controller states, in the order a run walks through them.
    typedef enum logic [3:0] {
        IDLE,
        M0_W,
        M1_RD,
        M1_WR,
        M2_RD,
        M2_WR,
        M3_RD,
        M3_DRAIN,
        DONE
    } state_e;

    // March element codes reported through fail_elem.
    localparam logic [1:0] ELEM_M0 = 2'd0;
    localparam logic [1:0] ELEM_M1 = 2'd1;
    localparam logic [1:0] ELEM_M2 = 2'd2;
    localparam logic [1:0] ELEM_M3 = 2'd3;

    // Widest data word the helper below handles; callers cast down to their width.
    localparam int DATA_MAX = 1024;

    // Value a read is expected to return in a given march element.
    // Only M2 reads back the inverted background; every other element expects bg.
    function automatic logic [DATA_MAX-1:0] exp_data(input logic [1:0] elem,
                                                     input logic [DATA_MAX-1:0] bg);
        return (elem == ELEM_M2) ? ~bg : bg;
    endfunction

endpackage

// File: rtl/mem_1r1w_bist_if.sv
// R0/W0 port bundle between the BIST controller and a lowered 1R1W memory.
interface mem_1r1w_bist_if #(
    parameter int ADDR_W = 6,
    parameter int WIDTH  = 64
);
    logic [ADDR_W-1:0] R0_addr;
    logic              R0_en;
    logic [WIDTH-1:0]  R0_data;
    logic [ADDR_W-1:0] W0_addr;
    logic              W0_en;
    logic [WIDTH-1:0]  W0_data;

    // The BIST is the client: it drives addresses, enables and write data.
    modport master (
        output R0_addr, R0_en, W0_addr, W0_en, W0_data,
        input  R0_data
    );

    // The memory answers with read data one cycle after R0_en.
    modport slave (
        input  R0_addr, R0_en, W0_addr, W0_en, W0_data,
        output R0_data
    );
endinterface

// File: rtl/mem_1r1w_bist_checker.sv
// Read-data comparator: counts miscompares and remembers the first one.
module mem_bist_checker
    import mem_bist_pkg::*;
#(
    parameter int WIDTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              compare_valid,
    input  logic [WIDTH-1:0]  expected,
    input  logic [WIDTH-1:0]  r0_data,
    input  logic [ADDR_W-1:0] addr,
    input  logic [1:0]        elem,
    output logic [15:0]       err_count,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [1:0]        fail_elem,
    output logic [WIDTH-1:0]  fail_syndrome,
    output logic              err_zero_next
);

    logic [15:0]       err_count_q, err_count_d;
    logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
    logic [1:0]        fail_elem_q, fail_elem_d;
    logic [WIDTH-1:0]  fail_syndrome_q, fail_syndrome_d;
    logic [WIDTH-1:0]  syndrome;
    logic              miscompare;

    // Compare, saturate the error count, and latch the failure details only for the first miscompare.
    always_comb begin
        syndrome        = r0_data ^ expected;
        miscompare      = compare_valid && (syndrome != '0);
        err_count_d     = err_count_q;
        fail_addr_d     = fail_addr_q;
        fail_elem_d     = fail_elem_q;
        fail_syndrome_d = fail_syndrome_q;
        if (clear) begin
            err_count_d     = '0;
            fail_addr_d     = '0;
            fail_elem_d     = '0;
            fail_syndrome_d = '0;
        end else if (miscompare) begin
            if (err_count_q != 16'hFFFF) begin
                err_count_d = err_count_q + 16'd1;
            end
            if (err_count_q == 16'd0) begin
                fail_addr_d     = addr;
                fail_elem_d     = elem;
                fail_syndrome_d = syndrome;
            end
        end
        err_zero_next = (err_count_d == 16'd0);
    end

    // Result registers, cleared asynchronously.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            err_count_q     <= '0;
            fail_addr_q     <= '0;
            fail_elem_q     <= '0;
            fail_syndrome_q <= '0;
        end else begin
            err_count_q     <= err_count_d;
            fail_addr_q     <= fail_addr_d;
            fail_elem_q     <= fail_elem_d;
            fail_syndrome_q <= fail_syndrome_d;
        end
    end

    assign err_count     = err_count_q;
    assign fail_addr     = fail_addr_q;
    assign fail_elem     = fail_elem_q;
    assign fail_syndrome = fail_syndrome_q;

endmodule

// File: rtl/mem_1r1w_bist.sv
// March C- style BIST controller for one lowered 1R1W memory:
// W(bg) up, R(bg)W(~bg) up, R(~bg)W(bg) down, R(bg) up.
module mem_1r1w_bist
    import mem_bist_pkg::*;
#(
    parameter int              DEPTH  = 48,
    parameter int              WIDTH  = 64,
    parameter int              ADDR_W = 6,
    parameter logic [WIDTH-1:0] BG    = {(WIDTH/2){2'b01}}
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                start,
    mem_1r1w_bist_if.master     mem,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [15:0]         err_count,
    output logic [ADDR_W-1:0]   fail_addr,
    output logic [1:0]          fail_elem,
    output logic [WIDTH-1:0]    fail_syndrome
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              start_run;

    logic              r0_en_q, r0_en_d;
    logic [ADDR_W-1:0] r0_addr_q, r0_addr_d;
    logic [1:0]        r0_elem_q, r0_elem_d;
    logic              w0_en_q, w0_en_d;
    logic [ADDR_W-1:0] w0_addr_q, w0_addr_d;
    logic [WIDTH-1:0]  w0_data_q, w0_data_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;

    logic              rd_pend_q, rd_pend_d;
    logic [ADDR_W-1:0] rd_pend_addr_q, rd_pend_addr_d;
    logic [1:0]        rd_pend_elem_q, rd_pend_elem_d;

    logic [WIDTH-1:0]  expected;
    logic              err_zero_next;

    // Next state and address: M2 walks down from DEPTH-1, everything else walks up.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        start_run = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    start_run = 1'b1;
                    state_d   = M0_W;
                    addr_d    = '0;
                end
            end
            M0_W: begin
                if (addr_q == LAST) begin
                    state_d = M1_RD;
                    addr_d  = '0;
                end else begin
                    addr_d = addr_q + ADDR_W'(1);
                end
            end
            M1_RD: state_d = M1_WR;
            M1_WR: begin
                if (addr_q == LAST) begin
                    state_d = M2_RD;
                    addr_d  = LAST;
                end else begin
                    state_d = M1_RD;
                    addr_d  = addr_q + ADDR_W'(1);
                end
            end
            M2_RD: state_d = M2_WR;
            M2_WR: begin
                if (addr_q == '0) begin
                    state_d = M3_RD;
                    addr_d  = '0;
                end else begin
                    state_d = M2_RD;
                    addr_d  = addr_q - ADDR_W'(1);
                end
            end
            M3_RD: begin
                if (addr_q == LAST) begin
                    state_d = M3_DRAIN;
                    addr_d  = '0;
                end else begin
                    addr_d = addr_q + ADDR_W'(1);
                end
            end
            M3_DRAIN: state_d = DONE;
            DONE:     state_d = IDLE;
            default: begin
                state_d = IDLE;
                addr_d  = '0;
            end
        endcase
    end

    // Decode the upcoming state into registered port values; idle ports park at zero.
    always_comb begin
        r0_en_d        = 1'b0;
        r0_addr_d      = '0;
        r0_elem_d      = ELEM_M0;
        w0_en_d        = 1'b0;
        w0_addr_d      = '0;
        w0_data_d      = '0;
        busy_d         = (state_d != IDLE) && (state_d != DONE);
        done_d         = (state_d == DONE);
        pass_d         = pass_q;
        if (start_run) begin
            pass_d = 1'b0;
        end else if (state_d == DONE) begin
            pass_d = err_zero_next;
        end
        case (state_d)
            M0_W: begin
                w0_en_d   = 1'b1;
                w0_addr_d = addr_d;
                w0_data_d = BG;
            end
            M1_RD: begin
                r0_en_d   = 1'b1;
                r0_addr_d = addr_d;
                r0_elem_d = ELEM_M1;
            end
            M1_WR: begin
                w0_en_d   = 1'b1;
                w0_addr_d = addr_d;
                w0_data_d = ~BG;
            end
            M2_RD: begin
                r0_en_d   = 1'b1;
                r0_addr_d = addr_d;
                r0_elem_d = ELEM_M2;
            end
            M2_WR: begin
                w0_en_d   = 1'b1;
                w0_addr_d = addr_d;
                w0_data_d = BG;
            end
            M3_RD: begin
                r0_en_d   = 1'b1;
                r0_addr_d = addr_d;
                r0_elem_d = ELEM_M3;
            end
            default: begin
            end
        endcase
        rd_pend_d      = r0_en_q;
        rd_pend_addr_d = r0_addr_q;
        rd_pend_elem_d = r0_elem_q;
    end

    // State, port and read-tracking registers; reset aborts any run in progress.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            addr_q         <= '0;
            r0_en_q        <= 1'b0;
            r0_addr_q      <= '0;
            r0_elem_q      <= ELEM_M0;
            w0_en_q        <= 1'b0;
            w0_addr_q      <= '0;
            w0_data_q      <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            pass_q         <= 1'b0;
            rd_pend_q      <= 1'b0;
            rd_pend_addr_q <= '0;
            rd_pend_elem_q <= ELEM_M0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            r0_en_q        <= r0_en_d;
            r0_addr_q      <= r0_addr_d;
            r0_elem_q      <= r0_elem_d;
            w0_en_q        <= w0_en_d;
            w0_addr_q      <= w0_addr_d;
            w0_data_q      <= w0_data_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            pass_q         <= pass_d;
            rd_pend_q      <= rd_pend_d;
            rd_pend_addr_q <= rd_pend_addr_d;
            rd_pend_elem_q <= rd_pend_elem_d;
        end
    end

    // Read data returns one cycle after R0_en, so the compare uses the delayed address/element.
    assign expected = WIDTH'(exp_data(rd_pend_elem_q, DATA_MAX'(BG)));

    mem_bist_checker #(
        .WIDTH  (WIDTH),
        .ADDR_W (ADDR_W)
    ) u_checker (
        .clock         (clock),
        .reset_n       (reset_n),
        .clear         (start_run),
        .compare_valid (rd_pend_q),
        .expected      (expected),
        .r0_data       (mem.R0_data),
        .addr          (rd_pend_addr_q),
        .elem          (rd_pend_elem_q),
        .err_count     (err_count),
        .fail_addr     (fail_addr),
        .fail_elem     (fail_elem),
        .fail_syndrome (fail_syndrome),
        .err_zero_next (err_zero_next)
    );

    assign mem.R0_en   = r0_en_q;
    assign mem.R0_addr = r0_addr_q;
    assign mem.W0_en   = w0_en_q;
    assign mem.W0_addr = w0_addr_q;
    assign mem.W0_data = w0_data_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign pass        = pass_q;

endmodule

// File: tb/tb_mem_1r1w_bist.sv
// Bench for mem_1r1w_bist: behavioural memory with an optional stuck-at bit,
// table of fault scenarios plus hand-written abort / restart sequences.
module tb_mem_1r1w_bist;

    localparam int          DEPTH   = 48;
    localparam int          WIDTH   = 64;
    localparam int          ADDR_W  = 6;
    localparam logic [63:0] BG      = 64'h5555_5555_5555_5555;
    localparam logic [63:0] NBG     = 64'hAAAA_AAAA_AAAA_AAAA;
    localparam int          RUN_LEN = 6 * DEPTH + 2;
    localparam int          MAX_CYC = 700;

    logic        clock;
    logic        reset_n;
    logic        start;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] err_count;
    logic [5:0]  fail_addr;
    logic [1:0]  fail_elem;
    logic [63:0] fail_syndrome;

    mem_1r1w_bist_if #(.ADDR_W(ADDR_W), .WIDTH(WIDTH)) mem_bus ();

    mem_1r1w_bist #(
        .DEPTH  (DEPTH),
        .WIDTH  (WIDTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .start         (start),
        .mem           (mem_bus),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .err_count     (err_count),
        .fail_addr     (fail_addr),
        .fail_elem     (fail_elem),
        .fail_syndrome (fail_syndrome)
    );

    // Free-running clock.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Fault injection controls for the behavioural memory.
    bit          fault_en;
    logic [5:0]  fault_addr;
    int          fault_bit;
    bit          fault_val;
    logic [63:0] mem_arr [0:DEPTH-1];

    function automatic logic [63:0] faulty(input logic [63:0] d, input logic [5:0] a);
        logic [63:0] mask;
        mask = 64'd1 << fault_bit;
        if (fault_en && a == fault_addr) begin
            return fault_val ? (d | mask) : (d & ~mask);
        end
        return d;
    endfunction

    // Synchronous 1R1W memory: read data appears the cycle after R0_en.
    always @(posedge clock) begin
        if (mem_bus.W0_en && mem_bus.W0_addr < 6'(DEPTH)) mem_arr[mem_bus.W0_addr] <= mem_bus.W0_data;
        if (mem_bus.R0_en && mem_bus.R0_addr < 6'(DEPTH)) mem_bus.R0_data <= faulty(mem_arr[mem_bus.R0_addr], mem_bus.R0_addr);
    end

    int checks;
    int errors;

    // Per-run observations.
    int done_cyc;
    int busy_cnt;
    int first_busy;
    int last_busy;
    int w_cnt;
    int r_cnt;
    int trace_err;
    int oob_cnt;
    int idle_nz;
    int extra_a;
    int extra_b;

    typedef struct {
        string       name;
        bit          f_en;
        logic [5:0]  f_addr;
        int          f_bit;
        bit          f_val;
        logic [15:0] e_err;
        logic [1:0]  e_elem;
        logic [5:0]  e_addr;
        logic [63:0] e_syn;
        bit          e_pass;
    } vec_t;

    vec_t vecs [5];

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Pulse (or hold) start, then watch the ports cycle by cycle until done, abort or timeout.
    task automatic apply_stimulus(input bit hold_start, input int abort_at);
        int rk;
        int wk;
        int ea;
        logic [63:0] ed;
        done_cyc = 0; busy_cnt = 0; first_busy = 0; last_busy = 0;
        w_cnt = 0; r_cnt = 0; trace_err = 0; oob_cnt = 0; idle_nz = 0;
        rk = 0; wk = 0;
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        #1;
        start = hold_start;
        for (int c = 1; c <= MAX_CYC; c++) begin
            @(negedge clock);
            start = hold_start || (c == extra_a) || (c == extra_b);
            if (c == abort_at) begin
                reset_n = 1'b0;
                break;
            end
            if (busy) begin
                busy_cnt++;
                if (first_busy == 0) first_busy = c;
                last_busy = c;
            end
            if (mem_bus.R0_en) begin
                ea = (rk < DEPTH) ? rk : (rk < 2 * DEPTH) ? (2 * DEPTH - 1 - rk) : (rk - 2 * DEPTH);
                if (rk >= 3 * DEPTH || int'(mem_bus.R0_addr) != ea) trace_err++;
                if (mem_bus.R0_addr >= 6'(DEPTH)) oob_cnt++;
                rk++; r_cnt++;
            end else if (mem_bus.R0_addr != '0) begin
                idle_nz++;
            end
            if (mem_bus.W0_en) begin
                ea = (wk < 2 * DEPTH) ? (wk % DEPTH) : (3 * DEPTH - 1 - wk);
                ed = (wk >= DEPTH && wk < 2 * DEPTH) ? NBG : BG;
                if (wk >= 3 * DEPTH || int'(mem_bus.W0_addr) != ea || mem_bus.W0_data != ed) trace_err++;
                if (mem_bus.W0_addr >= 6'(DEPTH)) oob_cnt++;
                wk++; w_cnt++;
            end else if (mem_bus.W0_addr != '0 || mem_bus.W0_data != '0) begin
                idle_nz++;
            end
            if (done) begin
                done_cyc = c;
                break;
            end
        end
    endtask

    // Standard end-of-run comparisons, taken in the done cycle.
    task automatic check_run(input string tag, input logic [15:0] e_err, input logic [1:0] e_elem,
                             input logic [5:0] e_addr, input logic [63:0] e_syn, input bit e_pass);
        check_output({tag, " done_cycle"}, done_cyc, RUN_LEN);
        check_output({tag, " busy_cycles"}, busy_cnt, 6 * DEPTH + 1);
        check_output({tag, " busy_first"}, first_busy, 1);
        check_output({tag, " w0_en_cycles"}, w_cnt, 3 * DEPTH);
        check_output({tag, " r0_en_cycles"}, r_cnt, 3 * DEPTH);
        check_output({tag, " addr_data_trace"}, trace_err, 0);
        check_output({tag, " addr_out_of_range"}, oob_cnt, 0);
        check_output({tag, " idle_port_zero"}, idle_nz, 0);
        check_output({tag, " busy_at_done"}, busy, 1'b0);
        check_output({tag, " pass"}, pass, e_pass);
        check_output({tag, " err_count"}, err_count, e_err);
        check_output({tag, " fail_elem"}, fail_elem, e_elem);
        check_output({tag, " fail_addr"}, fail_addr, e_addr);
        check_output({tag, " fail_syndrome"}, fail_syndrome, e_syn);
    endtask

    initial begin
        int seen;
        checks = 0; errors = 0;
        extra_a = 0; extra_b = 0;
        fault_en = 1'b0; fault_addr = '0; fault_bit = 0; fault_val = 1'b0;
        start = 1'b0;
        reset_n = 1'b0;

        vecs[0] = '{"clean",      1'b0, 6'd0,  0,  1'b0, 16'd0, 2'd0, 6'd0,  64'd0,          1'b1};
        vecs[1] = '{"sa0_b17_a5", 1'b1, 6'd5,  17, 1'b0, 16'd1, 2'd2, 6'd5,  64'h0000_0000_0002_0000, 1'b0};
        vecs[2] = '{"sa1_b0_a47", 1'b1, 6'd47, 0,  1'b1, 16'd1, 2'd2, 6'd47, 64'd1,          1'b0};
        vecs[3] = '{"sa1_b1_a3",  1'b1, 6'd3,  1,  1'b1, 16'd2, 2'd1, 6'd3,  64'd2,          1'b0};
        vecs[4] = '{"sa0_b0_a0",  1'b1, 6'd0,  0,  1'b0, 16'd2, 2'd1, 6'd0,  64'd1,          1'b0};

        // Reset state.
        repeat (3) @(negedge clock);
        check_output("reset busy", busy, 1'b0);
        check_output("reset done", done, 1'b0);
        check_output("reset pass", pass, 1'b0);
        check_output("reset err_count", err_count, 16'd0);
        check_output("reset r0_en", mem_bus.R0_en, 1'b0);
        check_output("reset w0_en", mem_bus.W0_en, 1'b0);
        check_output("reset w0_addr", mem_bus.W0_addr, 6'd0);
        check_output("reset w0_data", mem_bus.W0_data, 64'd0);
        reset_n = 1'b1;

        // Table of fault scenarios, each a full run.
        for (int i = 0; i < 5; i++) begin
            fault_en = vecs[i].f_en; fault_addr = vecs[i].f_addr;
            fault_bit = vecs[i].f_bit; fault_val = vecs[i].f_val;
            apply_stimulus(1'b0, 0);
            check_run(vecs[i].name, vecs[i].e_err, vecs[i].e_elem, vecs[i].e_addr, vecs[i].e_syn, vecs[i].e_pass);
            @(negedge clock);
            check_output({vecs[i].name, " done_one_cycle"}, done, 1'b0);
            check_output({vecs[i].name, " pass_held"}, pass, vecs[i].e_pass);
        end

        // Reset in the middle of a run: everything drops at once, no done pulse.
        fault_en = 1'b0;
        apply_stimulus(1'b0, 100);
        #1;
        check_output("abort r0_en", mem_bus.R0_en, 1'b0);
        check_output("abort w0_en", mem_bus.W0_en, 1'b0);
        check_output("abort busy", busy, 1'b0);
        check_output("abort done", done, 1'b0);
        check_output("abort done_cyc", done_cyc, 0);
        seen = 0;
        repeat (5) begin
            @(negedge clock);
            if (done || busy) seen++;
        end
        check_output("abort quiet", seen, 0);
        reset_n = 1'b1;
        apply_stimulus(1'b0, 0);
        check_run("after_abort", 16'd0, 2'd0, 6'd0, 64'd0, 1'b1);

        // Stray start pulses mid-run are ignored and do not clear the error count.
        fault_en = 1'b1; fault_addr = 6'd3; fault_bit = 1; fault_val = 1'b1;
        extra_a = 50; extra_b = 150;
        apply_stimulus(1'b0, 0);
        extra_a = 0; extra_b = 0;
        check_run("extra_start", 16'd2, 2'd1, 6'd3, 64'd2, 1'b0);

        // start held through DONE: one IDLE cycle, then a second run.
        fault_en = 1'b0;
        @(negedge clock);
        apply_stimulus(1'b1, 0);
        check_output("held first done_cycle", done_cyc, RUN_LEN);
        check_output("held first pass", pass, 1'b1);
        @(negedge clock);
        check_output("held idle busy", busy, 1'b0);
        @(negedge clock);
        check_output("held restart busy", busy, 1'b1);
        check_output("held restart pass_cleared", pass, 1'b0);
        start = 1'b0;
        done_cyc = 0;
        for (int c = RUN_LEN + 3; c <= RUN_LEN + 2 + MAX_CYC; c++) begin
            @(negedge clock);
            if (done) begin
                done_cyc = c;
                break;
            end
        end
        check_output("held second done_cycle", done_cyc, 2 * RUN_LEN + 1);
        check_output("held second pass", pass, 1'b1);
        check_output("held second err_count", err_count, 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
